// File: rtl/self_test_master_if.sv
// Self-test link bundle between the base-layer initiator and whoever
// drives/observes it (control logic on one side, the vertical bus on the
// other).
//   start, chip_id     : test request and target layer id
//   data_in            : response word coming down from the upper layers
//   data_out           : frame word driven up the vertical bus
//   busy, done         : run status / one-cycle completion pulse
//   pass, timeout,
//   remote_err         : result of the last completed test
interface self_test_master_if;
  logic        start;
  logic [2:0]  chip_id;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [3:0]  remote_err;

  modport master (
    input  start, chip_id, data_in,
    output data_out, busy, done, pass, timeout, remote_err
  );

  modport slave (
    output start, chip_id, data_in,
    input  data_out, busy, done, pass, timeout, remote_err
  );
endinterface

// File: rtl/self_test_master.sv
// Base-layer initiator of the 3D-stack self-test link.
// Sends a header (BEAF marker + target chip id) and 15 pattern words on the
// vertical bus, then waits for the addressed layer's CAFE completion word
// and reports pass / remote error count, or a timeout.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : self_test_master_if.master (start, chip_id, data_in in;
//                data_out, busy, done, pass, timeout, remote_err out)
// All bus outputs are registered; they are computed from the next state so
// that they take their new values on the same edge as the state change.
module self_test_master #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  self_test_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAT,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [2:0]        id_q, id_d;
  logic [3:0]        k_q, k_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [31:0]       dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;
  logic [3:0]        rerr_q, rerr_d;

  logic              resp_ok;
  logic              expired;
  logic              unused_bits;

  // Response match only looks at the marker and id fields; the error count
  // sits in [27:24] and everything else is don't-care.
  assign resp_ok     = (bus.data_in[15:0] == 16'hCAFE) &&
                       (bus.data_in[18:16] == id_q);
  assign expired     = (timer_q == TO_LAST);
  assign unused_bits = ^{bus.data_in[31:28], bus.data_in[23:19]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      k_q     <= '0;
      timer_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      rerr_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      k_q     <= k_d;
      timer_q <= timer_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    k_d     = k_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    to_d    = to_q;
    rerr_d  = rerr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          id_d    = bus.chip_id;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          rerr_d  = '0;
          k_d     = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        k_d     = 4'd1;
        state_d = S_PAT;
      end
      S_PAT: begin
        // k wraps 15 -> 0 on the way out, leaving the index cleared.
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Response is checked first so it wins over a same-cycle expiry.
        if (resp_ok) begin
          rerr_d  = bus.data_in[27:24];
          pass_d  = (bus.data_in[27:24] == 4'd0);
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (expired) begin
          rerr_d  = '0;
          pass_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_HDR) || (state_d == S_PAT) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);

    case (state_d)
      S_HDR:   dout_d = {13'h0, id_d, 16'hBEAF};
      S_PAT:   dout_d = {8{k_d}};
      default: dout_d = '0;
    endcase
  end

  assign bus.data_out   = dout_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = to_q;
  assign bus.remote_err = rerr_q;

endmodule

// File: tb/tb_self_test_master.sv
module tb_self_test_master;

  localparam int TIMEOUT = 64;
  localparam int TO_W    = 8;

  typedef struct {
    logic       pass;
    logic       to;
    logic [3:0] rerr;
  } res_t;

  logic clk;
  logic rst_n;

  self_test_master_if bus();

  self_test_master #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  res_t        res_q[$];

  // Scoreboard monitor: frame words and results are compared on the falling
  // edge, well away from the rising edge where the DUT updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.data_out !== e || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_word: data_out=%h busy=%b, expected %h busy=1",
                   bus.data_out, bus.busy, e);
        end
      end
      if (bus.done === 1'b1) begin
        n_checks++;
        if (res_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done=1, expected no completion");
        end else begin
          res_t r;
          r = res_q.pop_front();
          if (bus.pass !== r.pass || bus.timeout !== r.to || bus.remote_err !== r.rerr) begin
            n_fail++;
            $display("FAIL result: pass=%b timeout=%b remote_err=%h, expected pass=%b timeout=%b remote_err=%h",
                     bus.pass, bus.timeout, bus.remote_err, r.pass, r.to, r.rerr);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge and queue the frame plus the expected result.
  // Returns in the header cycle (cycle 1 of the run).
  task automatic do_start(input logic [2:0] id, input logic ep, input logic eto,
                          input logic [3:0] erv);
    res_t r;
    bus.chip_id = id;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.chip_id = 3'($urandom_range(0, 7));
    exp_q.push_back({13'h0, id, 16'hBEAF});
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      exp_q.push_back({8{kk}});
    end
    r.pass = ep;
    r.to   = eto;
    r.rerr = erv;
    res_q.push_back(r);
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.chip_id = 3'd0;
    bus.data_in = 32'h0;
    #3;
    n_checks++;
    if (bus.data_out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.pass !== 1'b0 || bus.timeout !== 1'b0 || bus.remote_err !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: data_out=%h busy=%b done=%b pass=%b timeout=%b remote_err=%h, expected all zero",
               bus.data_out, bus.busy, bus.done, bus.pass, bus.timeout, bus.remote_err);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_pass;
    do_start(3'd2, 1'b1, 1'b0, 4'h0);
    tick(16);                       // first WAIT cycle
    n_checks++;
    if (bus.data_out !== 32'h0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_entry: data_out=%h busy=%b, expected 0 busy=1", bus.data_out, bus.busy);
    end
    tick(2);                        // third WAIT cycle
    bus.data_in = 32'h0002_CAFE;
    tick();
    bus.data_in = 32'h0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_done: done=%b busy=%b, expected done=1 busy=0", bus.done, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.pass !== 1'b1 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_hold: done=%b pass=%b timeout=%b, expected done=0 pass=1 timeout=0",
               bus.done, bus.pass, bus.timeout);
    end
  endtask

  task automatic test_remote_err;
    do_start(3'd5, 1'b0, 1'b0, 4'h3);
    n_checks++;
    if (bus.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_clear_on_start: pass=%b, expected 0", bus.pass);
    end
    tick(16);
    bus.data_in = 32'h0305_CAFE;
    tick();
    bus.data_in = 32'h0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL rerr_done: done=%b, expected 1", bus.done);
    end
    tick(2);
  endtask

  task automatic test_wrong_id;
    do_start(3'd1, 1'b0, 1'b1, 4'h0);
    tick(16);                       // W1
    bus.data_in = 32'h0004_CAFE;
    tick();                         // W2
    bus.data_in = 32'h0;
    tick(62);                       // W64: last WAIT cycle
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: done=%b busy=%b, expected done=0 busy=1", bus.done, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_edge: done=%b timeout=%b pass=%b, expected 1 1 0",
               bus.done, bus.timeout, bus.pass);
    end
    tick(2);
  endtask

  task automatic test_early_resp;
    do_start(3'd1, 1'b0, 1'b1, 4'h0);
    bus.data_in = 32'h0001_CAFE;    // present through HDR and all of PAT
    tick(16);                       // W1
    bus.data_in = 32'h0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL early_resp: busy=%b done=%b, expected busy=1 done=0", bus.busy, bus.done);
    end
    tick(63);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL early_resp_wait: done=%b, expected 0", bus.done);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b1 || bus.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL early_resp_timeout: done=%b timeout=%b, expected 1 1", bus.done, bus.timeout);
    end
    tick(2);
  endtask

  task automatic test_back_to_back;
    do_start(3'd6, 1'b0, 1'b0, 4'hA);
    n_checks++;
    if (bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear_on_start: timeout=%b, expected 0", bus.timeout);
    end
    tick(4);                        // cycle 5
    bus.start   = 1'b1;
    bus.chip_id = 3'd3;
    tick();
    bus.start   = 1'b0;
    tick(14);                       // cycle 20 (WAIT)
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.data_in = 32'h0A06_CAFE;
    tick();                         // DONE
    bus.data_in = 32'h0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b, expected 1", bus.done);
    end
    bus.start = 1'b1;               // start in DONE must be dropped
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data_out !== 32'h0 || bus.remote_err !== 4'hA) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b data_out=%h remote_err=%h, expected busy=0 data_out=0 remote_err=a",
               bus.busy, bus.data_out, bus.remote_err);
    end
    do_start(3'd7, 1'b1, 1'b0, 4'h0);
    n_checks++;
    if (bus.remote_err !== 4'h0 || bus.pass !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL result_clear: remote_err=%h pass=%b timeout=%b, expected 0 0 0",
               bus.remote_err, bus.pass, bus.timeout);
    end
    tick(16);
    bus.data_in = 32'h0007_CAFE;
    tick();
    bus.data_in = 32'h0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    do_start(3'd4, 1'b1, 1'b0, 4'h0);
    tick(7);                        // cycle 8: pattern k=7 on the bus
    exp_q.delete();
    res_q.delete();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.data_out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: data_out=%h busy=%b done=%b, expected 0 0 0",
               bus.data_out, bus.busy, bus.done);
    end
    tick(2);
    rst_n = 1'b1;
    tick();
    do_start(3'd4, 1'b1, 1'b0, 4'h0);
    tick(16);
    bus.data_in = 32'h0004_CAFE;
    tick();
    bus.data_in = 32'h0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_done: done=%b, expected 1", bus.done);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_remote_err();
    test_wrong_id();
    test_early_resp();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d words and %0d results left, expected 0 and 0",
               exp_q.size(), res_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
